// File: rtl/psg_tone_mixer_pkg.sv
// psg_pkg: register offsets and width derivations shared by the tone mixer files.
package psg_pkg;
    localparam int REG_PERIOD = 0;
    localparam int REG_CTRL   = 1;

    function automatic int psg_en_bit(input int volw);
        return volw;
    endfunction

    function automatic int psg_mixw(input int nch, input int volw);
        return volw + $clog2(nch + 1);
    endfunction

    function automatic int psg_aw(input int nch);
        return $clog2(2 * nch);
    endfunction
endpackage

// File: rtl/psg_tone_mixer_if.sv
// psg_tone_mixer_if: register write port of the tone mixer.
interface psg_tone_mixer_if import psg_pkg::*; #(
    parameter int NCH  = 3,
    parameter int DIVW = 15
);
    localparam int AW = psg_aw(NCH);
    logic            WR_EN;
    logic [AW-1:0]   WR_ADDR;
    logic [DIVW-1:0] WR_DATA;
    modport master (output WR_EN, WR_ADDR, WR_DATA);
    modport slave  (input  WR_EN, WR_ADDR, WR_DATA);
endinterface

// File: rtl/psg_tone_mixer_chan.sv
// psg_tone_chan: one square-wave divider advanced on the shared tone tick.
module psg_tone_chan #(
    parameter int DIVW = 15
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_tick,
    input  logic            i_en,
    input  logic [DIVW-1:0] i_period,
    output logic            o_tone
);
    logic [DIVW-1:0] r_cnt;
    logic            w_active;

    assign w_active = i_en && (i_period != '0);

    // >= compare lets a shortened period take effect on the next tick without wrap-around
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= DIVW'(1);
            o_tone <= 1'b0;
        end else if (!w_active) begin
            r_cnt  <= DIVW'(1);
            o_tone <= 1'b0;
        end else if (i_tick) begin
            r_cnt  <= (r_cnt >= i_period) ? DIVW'(1) : r_cnt + 1'b1;
            o_tone <= (r_cnt >= i_period) ? ~o_tone : o_tone;
        end
    end
endmodule

// File: rtl/psg_tone_mixer.sv
// psg_tone_mixer: NCH tone channels, volume-weighted mix and sigma-delta DAC bitstream.
module psg_tone_mixer import psg_pkg::*; #(
    parameter int NCH      = 3,
    parameter int DIVW     = 15,
    parameter int VOLW     = 4,
    parameter int PRESCALE = 8192
) (
    input  logic                           CLK_50MHZ,
    input  logic                           RESET_N,
    psg_tone_mixer_if.slave                bus,
    output logic [NCH-1:0]                 TONE,
    output logic [psg_mixw(NCH,VOLW)-1:0]  MIX,
    output logic                           DAC_OUT
);
    localparam int MIXW = psg_mixw(NCH, VOLW);
    localparam int AW   = psg_aw(NCH);
    localparam int PW   = $clog2(PRESCALE);
    localparam int EN   = psg_en_bit(VOLW);

    logic [DIVW-1:0] r_period [NCH];
    logic [VOLW:0]   r_ctrl   [NCH];
    logic [PW-1:0]   r_pre;
    logic [MIXW-1:0] r_acc;
    logic [MIXW-1:0] w_sum;
    logic [MIXW:0]   w_sd;
    logic            w_tick;

    // Addresses at or beyond 2*NCH match no channel and are dropped
    always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NCH; i++) begin
                r_period[i] <= '0;
                r_ctrl[i]   <= '0;
            end
        end else if (bus.WR_EN) begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.WR_ADDR == AW'(2 * i + REG_PERIOD))
                    r_period[i] <= bus.WR_DATA;
                if (bus.WR_ADDR == AW'(2 * i + REG_CTRL))
                    r_ctrl[i] <= bus.WR_DATA[VOLW:0];
            end
        end
    end

    assign w_tick = (r_pre == PW'(PRESCALE - 1));

    always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
        if (!RESET_N)
            r_pre <= '0;
        else
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        psg_tone_chan #(.DIVW(DIVW)) u_chan (
            .i_clk    (CLK_50MHZ),
            .i_rst_n  (RESET_N),
            .i_tick   (w_tick),
            .i_en     (r_ctrl[c][EN]),
            .i_period (r_period[c]),
            .o_tone   (TONE[c])
        );
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NCH; i++)
            w_sum = w_sum + (TONE[i] ? MIXW'(r_ctrl[i][VOLW-1:0]) : MIXW'(0));
    end

    // Carry out of the MIXW-bit accumulator is the first-order modulator output
    assign w_sd = {1'b0, r_acc} + {1'b0, MIX};

    always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            MIX     <= '0;
            r_acc   <= '0;
            DAC_OUT <= 1'b0;
        end else begin
            MIX     <= w_sum;
            r_acc   <= w_sd[MIXW-1:0];
            DAC_OUT <= w_sd[MIXW];
        end
    end
endmodule

// File: tb/tb_psg_tone_mixer.sv
// tb_psg_tone_mixer: directed and random writes checked against a tick-level behavioural model.
module tb_psg_tone_mixer;
    localparam int NCH = 3, DIVW = 15, VOLW = 4, PRE = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] tone;
    logic [5:0] mix;
    logic       dac;
    int         n_chk = 0, n_err = 0;
    bit         chk_on = 1'b0;

    psg_tone_mixer_if #(.NCH(NCH), .DIVW(DIVW)) bus ();

    psg_tone_mixer #(.NCH(NCH), .DIVW(DIVW), .VOLW(VOLW), .PRESCALE(PRE)) dut (
        .CLK_50MHZ (clk),
        .RESET_N   (rst_n),
        .bus       (bus),
        .TONE      (tone),
        .MIX       (mix),
        .DAC_OUT   (dac)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: each channel remembers ticks elapsed since its last edge and flips after PERIOD of them
    int m_pre = 0, m_mix = 0, m_acc = 0;
    int m_el [NCH] = '{default: 0};
    int m_per[NCH] = '{default: 0};
    int m_vol[NCH] = '{default: 0};
    bit m_en [NCH] = '{default: 0};
    bit m_tone[NCH] = '{default: 0};
    bit m_dac = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        bit tick;
        int s;
        if (!rst_n) begin
            m_pre = 0; m_mix = 0; m_acc = 0; m_dac = 0;
            for (int c = 0; c < NCH; c++) begin
                m_el[c] = 0; m_per[c] = 0; m_vol[c] = 0; m_en[c] = 0; m_tone[c] = 0;
            end
        end else begin
            tick  = (m_pre == PRE - 1);
            m_pre = (m_pre + 1) % PRE;
            s     = m_acc + m_mix;
            m_dac = (s >= 64);
            m_acc = s % 64;
            m_mix = 0;
            for (int c = 0; c < NCH; c++) if (m_tone[c]) m_mix += m_vol[c];
            for (int c = 0; c < NCH; c++) begin
                if (!m_en[c] || m_per[c] == 0) begin
                    m_el[c] = 0; m_tone[c] = 0;
                end else if (tick) begin
                    if (m_el[c] + 1 >= m_per[c]) begin
                        m_tone[c] = !m_tone[c]; m_el[c] = 0;
                    end else m_el[c]++;
                end
            end
            if (bus.WR_EN && bus.WR_ADDR < 2 * NCH) begin
                if (bus.WR_ADDR % 2 == 0) m_per[bus.WR_ADDR / 2] = int'(bus.WR_DATA);
                else begin
                    m_en[bus.WR_ADDR / 2]  = bus.WR_DATA[4];
                    m_vol[bus.WR_ADDR / 2] = int'(bus.WR_DATA[3:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("tone", int'(tone), int'({m_tone[2], m_tone[1], m_tone[0]}));
            chk("mix", int'(mix), m_mix);
            chk("dac", int'(dac), int'(m_dac));
        end
    end

    task automatic wr(input int a, input int d);
        bus.WR_EN = 1'b1; bus.WR_ADDR = 3'(a); bus.WR_DATA = 15'(d);
        @(negedge clk);
        bus.WR_EN = 1'b0;
    endtask

    initial begin
        int n;
        bit t0;
        bus.WR_EN = 1'b0; bus.WR_ADDR = '0; bus.WR_DATA = '0;
        repeat (3) @(negedge clk);
        chk("rst_tone", int'(tone), 0);
        chk("rst_mix", int'(mix), 0);
        chk("rst_dac", int'(dac), 0);
        rst_n = 1'b1;
        chk_on = 1'b1;

        wr(0, 3); wr(1, 'h1F);
        n = 0;
        while (!tone[0] && n < 100) begin @(negedge clk); n++; end
        chk("t35_rise", int'(tone[0]), 1);
        chk("t35_mix_lag", int'(mix), 0);
        n = 0;
        do begin
            @(negedge clk); n++;
            if (n == 1) chk("t35_mix_hi", int'(mix), 15);
        end while (tone[0] && n < 100);
        chk("t35_half", n, 12);

        wr(0, 0);
        repeat (20) @(negedge clk);
        chk("t36_off_tone", int'(tone[0]), 0);
        chk("t36_off_mix", int'(mix), 0);
        wr(0, 2);
        repeat (30) @(negedge clk);

        wr(0, 10);
        n = 0;
        while (m_el[0] != 6 && n < 200) begin @(negedge clk); n++; end
        chk("t37_reach7", m_el[0], 6);
        t0 = tone[0];
        wr(0, 3);
        n = 1;
        while (tone[0] == t0 && n < 40) begin @(negedge clk); n++; end
        chk("t37_fast", int'(n <= 5), 1);

        wr(1, 0);
        wr(0, 100); wr(2, 100); wr(4, 100);
        wr(1, 'h1F); wr(3, 'h1F); wr(5, 'h1F);
        n = 0;
        while (mix != 45 && n < 1000) begin @(negedge clk); n++; end
        chk("t38_mix45", int'(mix), 45);
        n = 0;
        for (int i = 0; i < 64; i++) begin @(negedge clk); n += int'(dac); end
        chk("t38_duty", n, 45);

        wr(6, 'h7FFF); wr(7, 'h7FFF);
        repeat (8) @(negedge clk);
        chk("t40_mix", int'(mix), 45);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                n = $urandom_range(0, 7);
                wr(n, (n % 2 == 0) ? $urandom_range(0, 6) : $urandom_range(0, 'h7FFF));
            end else @(negedge clk);
        end

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t39_async_tone", int'(tone), 0);
        chk("t39_async_mix", int'(mix), 0);
        chk("t39_async_dac", int'(dac), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wr(0, 1);
        bus.WR_EN = 1'b1; bus.WR_ADDR = 3'd1; bus.WR_DATA = 15'h11;
        @(negedge clk);
        bus.WR_EN = 1'b0;
        chk("t39_pre2", int'(tone[0]), 0);
        @(negedge clk);
        chk("t39_pre3", int'(tone[0]), 0);
        @(negedge clk);
        chk("t39_tick4", int'(tone[0]), 1);
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/psg_tone_mixer.md
PSG_TONE_MIXER -- requirements
Module: psg_tone_mixer

Interface
REQ-001 Parameter NCH, default 3, number of tone channels (1..8).
REQ-002 Parameter DIVW, default 15, period register and channel counter width.
REQ-003 Parameter VOLW, default 4, per-channel volume width.
REQ-004 Parameter PRESCALE, default 8192, system clocks per tone tick (>=2).
REQ-005 CLK_50MHZ  in  1  sole clock; all state on rising edge.
REQ-006 RESET_N  in  1  asynchronous, active-low reset.
REQ-007 WR_EN  in  1  register write strobe, one write per asserted cycle.
REQ-008 WR_ADDR  in  AW  register address; AW = clog2(2*NCH).
REQ-009 WR_DATA  in  DIVW  write data.
REQ-010 TONE  out  NCH  per-channel square-wave levels.
REQ-011 MIX  out  MIXW  registered weighted sum; MIXW = VOLW + clog2(NCH+1).
REQ-012 DAC_OUT  out  1  first-order sigma-delta bitstream of MIX.

Function
REQ-013 Register map: address 2c = PERIOD[c] (DIVW bits); address 2c+1 = CTRL[c]: bit VOLW is enable, bits VOLW-1:0 are volume; unused WR_DATA bits are ignored.
REQ-014 Writes to addresses >= 2*NCH have no effect.
REQ-015 A write updates the register on the WR_EN clock edge; the value is visible to channel logic from the next cycle.
REQ-016 The prescaler counts 0..PRESCALE-1, wraps to 0, and asserts internal TICK for one clock when at PRESCALE-1.
REQ-017 Each channel counter holds 1 through reset and while the channel is inactive.
REQ-018 A channel is inactive when its enable is 0 or PERIOD is 0: TONE[c] is forced 0 and its counter is held at 1.
REQ-019 On TICK, for an active channel: if counter >= PERIOD then TONE[c] toggles and the counter loads 1; otherwise the counter increments by 1.
REQ-020 For an active channel, half-period = PERIOD*PRESCALE clocks and full period = 2*PERIOD*PRESCALE clocks.
REQ-021 PERIOD reduced below the current count while active: the channel toggles on the next TICK (>= compare); there is no counter wrap-around.
REQ-022 PERIOD = 2^DIVW-1: the counter reaches its maximum and toggles without overflow.
REQ-023 A channel going inactive to active starts with TONE[c]=0 and counter 1; the first toggle occurs after PERIOD ticks.
REQ-024 A write coincident with TICK: channel logic on that edge uses the old register value.
REQ-025 MIX is registered every clock as sum over c of (TONE[c] ? VOL[c] : 0), giving 1-clock latency from TONE.
REQ-026 MIX never overflows; its maximum is NCH*(2^VOLW-1).
REQ-027 Sigma-delta: ACC is MIXW bits; each clock {carry, ACC} <= ACC + MIX; DAC_OUT is the registered carry.
REQ-028 DAC_OUT duty over 2^MIXW clocks equals MIX/2^MIXW exactly when MIX is constant.

Reset
REQ-029 On RESET_N low, asynchronously: prescaler=0, all counters=1, PERIOD=0, CTRL=0, TONE=0, MIX=0, ACC=0, DAC_OUT=0.
REQ-030 Reset asserted mid-operation aborts all activity immediately.
REQ-031 After release, the first TICK occurs PRESCALE clocks after the first clock edge with RESET_N high.

Structure
REQ-032 Package psg_pkg holds the register-offset constants (PERIOD=0, CTRL=1), the CTRL enable bit position function, and the MIXW/AW derivation functions.
REQ-033 Per-channel divider is sub-module psg_tone_chan (PERIOD, enable, TICK in; TONE out), instantiated NCH times by generate.
REQ-034 No derived clocks; TICK is used only as a clock enable.

Verification (PRESCALE=4, NCH=3, DIVW=15, VOLW=4)
REQ-035 Write PERIOD0=3, CTRL0=0x1F -> TONE[0] toggles every 12 clocks; MIX alternates 0/15, lagging TONE by 1 clock.
REQ-036 PERIOD0=0 with enable=1 -> TONE[0] stays 0 and MIX=0; then write PERIOD0=2 -> first toggle after 8 clocks.
REQ-037 Channel 0 running with PERIOD=10 and count at 7; write PERIOD=3 -> toggle on the next TICK.
REQ-038 All three channels high with VOL=15,15,15 -> MIX=45; DAC_OUT high for exactly 45 of 64 clocks.
REQ-039 Pulse RESET_N low mid-period, asynchronously between clock edges -> all outputs 0 immediately; after release, the first TICK comes 4 clocks later.
REQ-040 Write to address 6 and address 7 -> no register or output changes.
